// File: rtl/uart_reg_bank.sv
// uart_reg_bank: UART byte-stream command decoder driving a bank of NUM_CH registers
// clock/reset_n: rising-edge clock, async active-low reset
// rx_data/rx_valid: received byte strobe; bit7 op (1 = read), bits[6:0] channel
// tx_data/tx_send/tx_busy: read-response bytes, MSB first, paced by tx_busy
// vals: flattened register contents; upd_valid/upd_ch: write-commit pulse
// err/err_code: error pulse; 1 bad channel, 2 timeout, 3 read dropped (tx busy)
module uart_reg_bank #(
  parameter int NUM_CH = 4,
  parameter int VAL_BYTES = 2,
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic [7:0]                    tx_data,
  output logic                          tx_send,
  input  logic                          tx_busy,
  output logic [NUM_CH*VAL_BYTES*8-1:0] vals,
  output logic                          upd_valid,
  output logic [6:0]                    upd_ch,
  output logic                          err,
  output logic [1:0]                    err_code
);
  localparam int W = VAL_BYTES*8;
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [7:0] NCH = 8'(NUM_CH);
  localparam logic [2:0] LAST = 3'(VAL_BYTES-1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES-1);
  typedef enum logic [1:0] {R_IDLE, R_DATA, R_DISCARD} r_t;
  typedef enum logic [1:0] {T_IDLE, T_SEND, T_HOLD, T_WAIT} t_t;
  r_t rs;
  t_t ts;
  logic [W-1:0] regs [NUM_CH];
  logic [W-1:0] sh, snap, sh_n;
  logic [CW-1:0] ch;
  logic [2:0] cnt, tidx;
  logic [TW-1:0] tcnt;
  logic ok;
  assign sh_n = W'({sh, rx_data});
  assign ok = {1'b0, rx_data[6:0]} < NCH;
  for (genvar k = 0; k < NUM_CH; k++) begin : g_vals
    assign vals[k*W +: W] = regs[k];
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rs <= R_IDLE;
      ts <= T_IDLE;
      for (int i = 0; i < NUM_CH; i++) regs[i] <= '0;
      sh <= '0;
      snap <= '0;
      ch <= '0;
      cnt <= '0;
      tidx <= '0;
      tcnt <= '0;
      tx_data <= '0;
      tx_send <= 1'b0;
      upd_valid <= 1'b0;
      upd_ch <= '0;
      err <= 1'b0;
      err_code <= '0;
    end else begin
      tx_send <= 1'b0;
      upd_valid <= 1'b0;
      err <= 1'b0;
      if (rs == R_IDLE) begin
        if (rx_valid) begin
          tcnt <= '0;
          cnt <= '0;
          ch <= rx_data[CW-1:0];
          if (!ok) begin
            err <= 1'b1;
            err_code <= 2'd1;
            if (!rx_data[7]) rs <= R_DISCARD;
          end else if (!rx_data[7]) rs <= R_DATA;
          else if (ts != T_IDLE) begin
            err <= 1'b1;
            err_code <= 2'd3;
          end else begin
            snap <= regs[rx_data[CW-1:0]];
            tidx <= '0;
            ts <= T_SEND;
          end
        end
      end else if (rx_valid) begin
        tcnt <= '0;
        cnt <= cnt + 3'd1;
        sh <= sh_n;
        if (cnt == LAST) begin
          rs <= R_IDLE;
          if (rs == R_DATA) begin
            regs[ch] <= sh_n;
            upd_valid <= 1'b1;
            upd_ch <= 7'(ch);
          end
        end
      end else if (tcnt == TLAST) begin
        rs <= R_IDLE;
        err <= 1'b1;
        err_code <= 2'd2;
      end else tcnt <= tcnt + 1'b1;
      case (ts)
        T_SEND: if (!tx_busy) begin
          tx_data <= snap[W-1 -: 8];
          snap <= snap << 8;
          tx_send <= 1'b1;
          ts <= T_HOLD;
        end
        T_HOLD: ts <= T_WAIT;
        T_WAIT: if (!tx_busy) begin
          tidx <= tidx + 3'd1;
          ts <= tidx == LAST ? T_IDLE : T_SEND;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_reg_bank.sv
// tb_uart_reg_bank: directed scoreboard bench for uart_reg_bank
module tb_uart_reg_bank;
  logic clock, reset_n, rx_valid, tx_send, tx_busy, upd_valid, err;
  logic [7:0] rx_data, tx_data;
  logic [63:0] vals;
  logic [6:0] upd_ch;
  logic [1:0] err_code;
  int n_chk = 0, n_fail = 0, bcnt = 0;
  logic [7:0] exp_tx[$];
  logic [6:0] exp_upd[$];
  logic [1:0] exp_err[$];
  uart_reg_bank #(.NUM_CH(4), .VAL_BYTES(2), .TIMEOUT_CYCLES(50)) dut (
    .clock(clock), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy), .vals(vals),
    .upd_valid(upd_valid), .upd_ch(upd_ch), .err(err), .err_code(err_code)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) bcnt <= tx_send ? 10 : (bcnt > 0 ? bcnt - 1 : 0);
  assign tx_busy = bcnt != 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clock) if (reset_n) begin
    if (tx_send) begin
      chk("tx_send_while_busy", 64'(tx_busy), 64'd0);
      chk("tx_pending", 64'(exp_tx.size() > 0), 64'd1);
      if (exp_tx.size() > 0) chk("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
    end
    if (upd_valid) begin
      chk("upd_pending", 64'(exp_upd.size() > 0), 64'd1);
      if (exp_upd.size() > 0) chk("upd_ch", 64'(upd_ch), 64'(exp_upd.pop_front()));
    end
    if (err) begin
      chk("err_pending", 64'(exp_err.size() > 0), 64'd1);
      if (exp_err.size() > 0) chk("err_code", 64'(err_code), 64'(exp_err.pop_front()));
    end
    if (err || upd_valid) chk("err_upd_excl", 64'(err & upd_valid), 64'd0);
  end
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clock);
    rx_valid = 1'b0;
  endtask
  task automatic wait_tx();
    for (int i = 0; i < 400 && exp_tx.size() != 0; i++) @(negedge clock);
    chk("tx_done", 64'(exp_tx.size()), 64'd0);
    repeat (15) @(negedge clock);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_vals"}, vals, 64'd0);
    chk({tag, "_ctl"}, 64'({tx_send, upd_valid, err}), 64'd0);
    chk({tag, "_data"}, 64'({tx_data, err_code, upd_ch}), 64'd0);
  endtask
  initial begin
    reset_n = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clock);
    chk_zero("reset");
    reset_n = 1'b1;
    @(negedge clock);
    exp_upd.push_back(7'd1);
    send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
    chk("wr_ch1_pulse", 64'({upd_valid, upd_ch}), 64'h81);
    chk("wr_ch1", vals, 64'h0000_0000_1234_0000);
    @(negedge clock);
    chk("upd_one_cycle", 64'(upd_valid), 64'd0);
    exp_upd.push_back(7'd2);
    send_byte(8'h02); send_byte(8'hBE); send_byte(8'hEF);
    chk("wr_ch2", vals, 64'h0000_BEEF_1234_0000);
    exp_tx.push_back(8'hBE); exp_tx.push_back(8'hEF);
    send_byte(8'h82);
    wait_tx();
    exp_err.push_back(2'd1);
    send_byte(8'h05);
    chk("bad_ch_err", 64'({err, err_code}), 64'h5);
    send_byte(8'hAA); send_byte(8'hBB);
    chk("bad_ch_vals", vals, 64'h0000_BEEF_1234_0000);
    exp_upd.push_back(7'd0);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h07);
    chk("wr_ch0", vals, 64'h0000_BEEF_1234_0007);
    exp_err.push_back(2'd2);
    send_byte(8'h03); send_byte(8'h11);
    repeat (49) @(negedge clock);
    chk("timeout_early", 64'(err), 64'd0);
    @(negedge clock);
    chk("timeout_err", 64'({err, err_code}), 64'h6);
    chk("timeout_vals", vals, 64'h0000_BEEF_1234_0007);
    exp_upd.push_back(7'd3);
    send_byte(8'h03); send_byte(8'h22); send_byte(8'h33);
    chk("wr_ch3", vals, 64'h2233_BEEF_1234_0007);
    exp_tx.push_back(8'hBE); exp_tx.push_back(8'hEF);
    exp_upd.push_back(7'd2);
    send_byte(8'h82);
    send_byte(8'h02); send_byte(8'h55); send_byte(8'h66);
    chk("wr_during_rd", vals, 64'h2233_5566_1234_0007);
    wait_tx();
    exp_tx.push_back(8'h12); exp_tx.push_back(8'h34);
    exp_err.push_back(2'd3);
    send_byte(8'h81);
    send_byte(8'h80);
    chk("rd_busy_err", 64'({err, err_code}), 64'h7);
    wait_tx();
    send_byte(8'h00); send_byte(8'hFF);
    reset_n = 1'b0;
    #1;
    chk_zero("midframe_reset");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    exp_upd.push_back(7'd1);
    send_byte(8'h01); send_byte(8'hAB); send_byte(8'hCD);
    chk("post_reset_wr", vals, 64'h0000_0000_ABCD_0000);
    repeat (5) @(negedge clock);
    chk("tx_q_empty", 64'(exp_tx.size()), 64'd0);
    chk("upd_q_empty", 64'(exp_upd.size()), 64'd0);
    chk("err_q_empty", 64'(exp_err.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
